// File: rtl/array_sum.sv
// array_sum: streams a contiguous array from a 2R/1W memory, two
// elements per clock, accumulates an n-bit sum and writes it back.
// Ports: clk, rst (async, active-high); start/base_addr/len/dst_addr
// request; rd_addr1/rd_addr2 + rd_data1/rd_data2 read ports (registered
// read, 1-cycle latency); wr_addr/wr_data/wr_en write port; busy, done,
// result, ovf status.
// Build option: define ARRAY_SUM_SAT_EN for saturating accumulation;
// without it the sum wraps modulo 2^n.
module array_sum #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] base_addr,
    input  logic [n-1:0] len,
    input  logic [n-1:0] dst_addr,
    output logic [n-1:0] rd_addr1,
    output logic [n-1:0] rd_addr2,
    input  logic [n-1:0] rd_data1,
    input  logic [n-1:0] rd_data2,
    output logic [n-1:0] wr_addr,
    output logic [n-1:0] wr_data,
    output logic         wr_en,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         ovf
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam logic [n-1:0] ONE = 1;
    localparam logic [n-1:0] TWO = 2;

    state_t       state;
    logic [n-1:0] rem;
    logic [n-1:0] dst;
    logic [n-1:0] acc;
    logic         v1;
    logic         v2;

    logic [n-1:0] a1;
    logic [n-1:0] a2;
    logic [n:0]   s1;
    logic [n:0]   s2;
    logic         carry;
    logic [n-1:0] acc_next;

    // Slot masks make acc_next equal acc when no pair is in flight,
    // so the accumulator can be updated unconditionally every edge.
    always_comb begin
        a1    = v1 ? rd_data1 : '0;
        a2    = v2 ? rd_data2 : '0;
        s1    = {1'b0, acc} + {1'b0, a1};
        s2    = {1'b0, s1[n-1:0]} + {1'b0, a2};
        carry = s1[n] | s2[n];
`ifdef ARRAY_SUM_SAT_EN
        acc_next = carry ? '1 : s2[n-1:0];
`else
        acc_next = s2[n-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            dst      <= '0;
            acc      <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
        end else begin
            acc      <= acc_next;
            ovf      <= ovf | carry;
            v1       <= 1'b0;
            v2       <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        dst  <= dst_addr;
                        rem  <= len;
                        busy <= 1'b1;
                        if (len != '0) begin
                            state    <= READ;
                            rd_addr1 <= base_addr;
                            rd_addr2 <= base_addr + ONE;
                        end else begin
                            state   <= WRITE;
                            wr_en   <= 1'b1;
                            wr_addr <= dst_addr;
                        end
                    end
                end
                READ: begin
                    v1  <= 1'b1;
                    v2  <= (rem != ONE);
                    rem <= (rem > TWO) ? rem - TWO : '0;
                    if (rem <= TWO) begin
                        state <= DRAIN;
                    end else begin
                        rd_addr1 <= rd_addr1 + TWO;
                        rd_addr2 <= rd_addr2 + TWO;
                    end
                end
                DRAIN: begin
                    // Final pair lands on this edge; write the updated sum.
                    state   <= WRITE;
                    wr_en   <= 1'b1;
                    wr_addr <= dst;
                    wr_data <= acc_next;
                end
                WRITE: begin
                    state  <= DONE;
                    result <= wr_data;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_sum.sv
// tb_array_sum: directed test of array_sum against a behavioural
// two-read/one-write memory with registered reads.
module tb_array_sum;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic [7:0] dst_addr;
    logic [7:0] rd_addr1;
    logic [7:0] rd_addr2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       ovf;

    logic [7:0] mem [256];
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    int checks;
    int failures;

    logic [7:0] ra1 [1:4];
    logic [7:0] ra2 [1:4];

    array_sum #(.n(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .dst_addr  (dst_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data1 <= mem[rd_addr1];
        rd_data2 <= mem[rd_addr2];
        if (wr_en)
            mem[wr_addr] <= wr_data;
        else if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request; cycle 1 is the cycle after the accepting edge.
    task automatic run(
        input  logic [7:0] b,
        input  logic [7:0] l,
        input  logic [7:0] d,
        input  int         pulse,
        output int         wc,
        output int         dc,
        output int         wa,
        output int         wd,
        output int         rdnz
    );
        wc = 0; dc = 0; wa = 0; wd = 0; rdnz = 0;
        @(negedge clk);
        base_addr = b;
        len       = l;
        dst_addr  = d;
        start     = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == pulse);
            if (c <= 4) begin
                ra1[c] = rd_addr1;
                ra2[c] = rd_addr2;
            end
            if (rd_addr1 != 0 || rd_addr2 != 0) rdnz = 1;
            if (wr_en && wc == 0) begin
                wc = c;
                wa = wr_addr;
                wd = wr_data;
            end
            if (done) begin
                dc = c;
                break;
            end
        end
        start = 1'b0;
        check("run_timeout", int'(dc != 0), 1);
    endtask

    // Watch a number of cycles and count any write strobes.
    task automatic quiet(input int cycles, output int writes);
        writes = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (wr_en) writes++;
        end
    endtask

    int wc, dc, wa, wd, rdnz, nw, exp_res;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0;
        base_addr = '0; len = '0; dst_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_rd_addr1", rd_addr1, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;

        // len=4 basic sum
        load(0, 1); load(1, 2); load(2, 3); load(3, 4);
        run(0, 4, 128, 0, wc, dc, wa, wd, rdnz);
        check("l4_wr_cyc", wc, 4);
        check("l4_wr_addr", wa, 128);
        check("l4_wr_data", wd, 10);
        check("l4_done_cyc", dc, 5);
        @(negedge clk);
        check("l4_mem", mem[128], 10);
        check("l4_result", result, 10);
        check("l4_ovf", ovf, 0);
        check("l4_idle", busy, 0);

        // odd length masks second slot
        load(10, 5); load(11, 6); load(12, 7); load(13, 100);
        run(10, 3, 50, 0, wc, dc, wa, wd, rdnz);
        check("l3_wr_data", wd, 18);
        check("l3_wr_cyc", wc, 4);
        check("l3_done_cyc", dc, 5);

        // zero length writes 0 without reading
        load(7, 99);
        run(0, 0, 7, 0, wc, dc, wa, wd, rdnz);
        check("l0_wr_cyc", wc, 1);
        check("l0_wr_data", wd, 0);
        check("l0_done_cyc", dc, 2);
        check("l0_no_reads", rdnz, 0);
        @(negedge clk);
        check("l0_mem", mem[7], 0);

        // address wrap 254,255,0,1
        load(254, 11); load(255, 22); load(0, 33); load(1, 44);
        run(254, 4, 60, 0, wc, dc, wa, wd, rdnz);
        check("wrap_c1_a1", ra1[1], 254);
        check("wrap_c1_a2", ra2[1], 255);
        check("wrap_c2_a1", ra1[2], 0);
        check("wrap_c2_a2", ra2[2], 1);
        check("wrap_sum", wd, 110);

        // overflow
        load(20, 200); load(21, 100);
        run(20, 2, 61, 0, wc, dc, wa, wd, rdnz);
        @(negedge clk);
`ifdef ARRAY_SUM_SAT_EN
        exp_res = 255;
`else
        exp_res = 44;
`endif
        check("ovf_result", result, exp_res);
        check("ovf_flag", ovf, 1);
        check("ovf_mem", mem[61], exp_res);

        // reset in cycle 2 of a len=8 run aborts the write
        load(90, 77);
        @(negedge clk);
        base_addr = 0; len = 8; dst_addr = 90; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_c1", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet(12, nw);
        check("abort_no_write", nw, 0);
        check("abort_mem", mem[90], 77);

        // start pulsed mid-run is ignored
        load(0, 1); load(1, 2); load(2, 3); load(3, 4);
        run(0, 4, 129, 2, wc, dc, wa, wd, rdnz);
        check("ign_wr_data", wd, 10);
        check("ign_wr_cyc", wc, 4);
        check("ign_done_cyc", dc, 5);
        quiet(10, nw);
        check("ign_no_extra_write", nw, 0);
        check("ign_mem", mem[129], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
